// File: rtl/lm_sm_seq.sv
// -----------------------------------------------------------------------------
// lm_sm_seq -- load-multiple / store-multiple sequencer
//
// Walks the registers selected by an 8-bit mask in ascending order and moves
// each one between the register file and consecutive memory words, one word
// per memory handshake beat (mem_req & mem_rdy).
//
//   LM (is_lm=1): memory -> register file, written in the beat cycle.
//   SM (is_lm=0): register file -> memory, mem_wdata mirrors rf_rd_data.
//
// Ports
//   clk, rst               clock; synchronous active-high reset
//   start, is_lm,          launch request and its parameters, sampled in IDLE
//   base_addr, reg_mask
//   mem_req, mem_we,       memory request channel, held stable until mem_rdy
//   mem_addr, mem_wdata
//   mem_rdy, mem_rdata     memory ready / read data
//   rf_rd_addr,rf_rd_data  combinational register-file read port
//   rf_wr_en, rf_wr_addr,  register-file write port
//   rf_wr_data
//   busy, done             not-IDLE flag / one-cycle completion pulse
//
// Configuration
//   LMSM_PC_GUARD_EN  when defined, mask bit 7 (R7 = PC) is dropped at launch,
//                     so R7 is never transferred.
// -----------------------------------------------------------------------------
module lm_sm_seq #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         is_lm,
  input  logic [W-1:0] base_addr,
  input  logic [7:0]   reg_mask,
  output logic         mem_req,
  output logic         mem_we,
  output logic [W-1:0] mem_addr,
  output logic [W-1:0] mem_wdata,
  input  logic         mem_rdy,
  input  logic [W-1:0] mem_rdata,
  output logic [2:0]   rf_rd_addr,
  input  logic [W-1:0] rf_rd_data,
  output logic         rf_wr_en,
  output logic [2:0]   rf_wr_addr,
  output logic [W-1:0] rf_wr_data,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state, state_nxt;
  logic [7:0]   mask_q, mask_nxt;
  logic [W-1:0] cur_addr, addr_nxt;
  logic         lm_q, lm_nxt;

  logic [7:0]   eff_mask;
  logic [7:0]   mask_rest;
  logic [2:0]   idx;
  logic         beat;

  // Mask as latched at launch.
  always_comb begin
`ifdef LMSM_PC_GUARD_EN
    eff_mask = reg_mask & 8'h7F;
`else
    eff_mask = reg_mask;
`endif
  end

  // Lowest set bit of the latched mask: scanning from the top down lets the
  // lowest hit overwrite any higher one.
  always_comb begin
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask_q[i]) idx = 3'(i);
    end
  end

  // x & (x-1) clears exactly the lowest set bit, i.e. bit idx.
  assign mask_rest = mask_q & (mask_q - 8'd1);
  assign beat      = (state == XFER) && mem_rdy;

  // State and datapath registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mask_q   <= '0;
      cur_addr <= '0;
      lm_q     <= 1'b0;
    end else begin
      state    <= state_nxt;
      mask_q   <= mask_nxt;
      cur_addr <= addr_nxt;
      lm_q     <= lm_nxt;
    end
  end

  // Next-state logic.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    mask_nxt  = mask_q;
    addr_nxt  = cur_addr;
    lm_nxt    = lm_q;
    unique case (state)
      IDLE: begin
        if (start) begin
          lm_nxt    = is_lm;
          addr_nxt  = base_addr;
          mask_nxt  = eff_mask;
          state_nxt = (eff_mask != 8'd0) ? XFER : DONE;
        end
      end
      XFER: begin
        if (beat) begin
          mask_nxt = mask_rest;
          addr_nxt = cur_addr + W'(1);   // wraps naturally at the top
          if (mask_rest == 8'd0) state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;        // start in this cycle is ignored
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: the request channel is only live in XFER and is zero elsewhere.
  always_comb begin
    busy       = (state != IDLE);
    done       = (state == DONE);
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    rf_rd_addr = 3'd0;
    rf_wr_en   = 1'b0;
    rf_wr_addr = 3'd0;
    rf_wr_data = '0;
    if (state == XFER) begin
      mem_req    = 1'b1;
      mem_we     = ~lm_q;
      mem_addr   = cur_addr;
      rf_rd_addr = idx;
      mem_wdata  = rf_rd_data;
      rf_wr_en   = beat && lm_q;
      rf_wr_addr = idx;
      rf_wr_data = mem_rdata;
    end
  end

endmodule

// File: tb/tb_lm_sm_seq.sv
// -----------------------------------------------------------------------------
// tb_lm_sm_seq -- self-checking bench for lm_sm_seq.
// The reference model turns each launch into a list of (register, address)
// beats; every cycle the DUT outputs are compared against the next pending
// beat, or against the done pulse once the list is exhausted.
// -----------------------------------------------------------------------------
module tb_lm_sm_seq;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         is_lm;
  logic [W-1:0] base_addr;
  logic [7:0]   reg_mask;
  logic         mem_req;
  logic         mem_we;
  logic [W-1:0] mem_addr;
  logic [W-1:0] mem_wdata;
  logic         mem_rdy;
  logic [W-1:0] mem_rdata;
  logic [2:0]   rf_rd_addr;
  logic [W-1:0] rf_rd_data;
  logic         rf_wr_en;
  logic [2:0]   rf_wr_addr;
  logic [W-1:0] rf_wr_data;
  logic         busy;
  logic         done;

  logic [W-1:0] rf [8];
  assign rf_rd_data = rf[rf_rd_addr];

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  lm_sm_seq #(.W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .is_lm      (is_lm),
    .base_addr  (base_addr),
    .reg_mask   (reg_mask),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdy    (mem_rdy),
    .mem_rdata  (mem_rdata),
    .rf_rd_addr (rf_rd_addr),
    .rf_rd_data (rf_rd_data),
    .rf_wr_en   (rf_wr_en),
    .rf_wr_addr (rf_wr_addr),
    .rf_wr_data (rf_wr_data),
    .busy       (busy),
    .done       (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled mid-low-phase.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".busy"},       busy,       0);
    check({tag, ".done"},       done,       0);
    check({tag, ".mem_req"},    mem_req,    0);
    check({tag, ".mem_we"},     mem_we,     0);
    check({tag, ".rf_wr_en"},   rf_wr_en,   0);
    check({tag, ".mem_addr"},   mem_addr,   0);
    check({tag, ".mem_wdata"},  mem_wdata,  0);
    check({tag, ".rf_rd_addr"}, rf_rd_addr, 0);
    check({tag, ".rf_wr_addr"}, rf_wr_addr, 0);
  endtask

  // One complete launch. stalls: rdy-low cycles before every beat (ignored
  // when rand_stall). fix_data forces mem_rdata to fix_val.
  task automatic run(input string tag, input bit lm, input logic [15:0] base,
                     input logic [7:0] mask, input int stalls, input bit rand_stall,
                     input bit fix_data, input logic [15:0] fix_val);
    logic [7:0]  eff;
    logic [15:0] exp_addr;
    int          regs[$];
    int          k;
    int          stall_left;
    bit          seen_req;
    eff = mask;
`ifdef LMSM_PC_GUARD_EN
    eff[7] = 1'b0;
`endif
    for (int i = 0; i < 8; i++) if (eff[i]) regs.push_back(i);
    for (int i = 0; i < 8; i++) rf[i] = 16'($urandom);

    start = 1'b1; is_lm = lm; base_addr = base; reg_mask = mask;
    mem_rdy = 1'b0; mem_rdata = '0;
    #1 check({tag, ".c0.busy"}, busy, 0);

    k = 0;
    seen_req = 1'b0;
    stall_left = rand_stall ? $urandom_range(0, 2) : stalls;
    while (1) begin
      step();
      // Launch inputs are scrambled while busy; they must have no effect.
      start     = 1'($urandom);
      is_lm     = 1'($urandom);
      base_addr = 16'($urandom);
      reg_mask  = 8'($urandom);
      mem_rdata = fix_data ? fix_val : 16'($urandom);
      mem_rdy   = (k < regs.size()) ? (stall_left == 0) : 1'($urandom);
      #1;
      if (k < regs.size()) begin
        exp_addr = base + 16'(k);
        seen_req = 1'b1;
        check({tag, ".busy"},       busy,       1);
        check({tag, ".done"},       done,       0);
        check({tag, ".mem_req"},    mem_req,    1);
        check({tag, ".mem_we"},     mem_we,     !lm);
        check({tag, ".mem_addr"},   mem_addr,   exp_addr);
        check({tag, ".rf_rd_addr"}, rf_rd_addr, regs[k]);
        check({tag, ".mem_wdata"},  mem_wdata,  rf[regs[k]]);
        check({tag, ".rf_wr_en"},   rf_wr_en,   lm && mem_rdy);
        if (lm && mem_rdy) begin
          check({tag, ".rf_wr_addr"}, rf_wr_addr, regs[k]);
          check({tag, ".rf_wr_data"}, rf_wr_data, fix_data ? fix_val : mem_rdata);
        end
        if (mem_rdy) begin
          k++;
          stall_left = rand_stall ? $urandom_range(0, 2) : stalls;
        end else begin
          stall_left--;
        end
      end else begin
        check({tag, ".done"},     done,     1);
        check({tag, ".busy"},     busy,     1);
        check({tag, ".dmem_req"}, mem_req,  0);
        check({tag, ".dmem_we"},  mem_we,   0);
        check({tag, ".drf_wr"},   rf_wr_en, 0);
        break;
      end
    end
    if (regs.size() == 0) check({tag, ".no_req"}, seen_req, 0);
    step();
    start = 1'b0;
    mem_rdy = 1'($urandom);
    #1 check_idle({tag, ".after"});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; is_lm = 1'b0; base_addr = '0; reg_mask = '0;
    mem_rdy = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 8; i++) rf[i] = '0;
    @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    step();
    rst = 1'b0;
    #1 check_idle("reset_rel");

    // Directed cases.
    run("sm_05",   1'b0, 16'h0100, 8'h05, 0, 1'b0, 1'b0, 16'h0);
    run("lm_0a",   1'b1, 16'h0200, 8'h0A, 0, 1'b0, 1'b1, 16'hBEEF);
    run("empty",   1'b1, 16'h1234, 8'h00, 0, 1'b0, 1'b0, 16'h0);
    run("stall3",  1'b1, 16'h0300, 8'h01, 3, 1'b0, 1'b0, 16'h0);
    run("wrap",    1'b0, 16'hFFFF, 8'h03, 0, 1'b0, 1'b0, 16'h0);
    run("r7",      1'b1, 16'h0400, 8'h80, 0, 1'b0, 1'b0, 16'h0);
    run("full_sm", 1'b0, 16'hFFFC, 8'hFF, 0, 1'b1, 1'b0, 16'h0);

    // Reset in mid-sequence after the first beat of mask 0xFF.
    start = 1'b1; is_lm = 1'b1; base_addr = 16'h0500; reg_mask = 8'hFF; mem_rdy = 1'b0;
    step();
    start = 1'b0; mem_rdy = 1'b1;
    #1 check("abort.beat0", rf_rd_addr, 0);
    step();
    rst = 1'b1; mem_rdy = 1'b0;
    step();
    rst = 1'b0; mem_rdy = 1'b1;
    #1 check_idle("abort.next");
    for (int c = 0; c < 4; c++) begin
      step();
      #1;
      check("abort.no_done", done, 0);
      check("abort.no_req",  mem_req, 0);
    end

    // Reset wins over a simultaneous start.
    rst = 1'b1; start = 1'b1; reg_mask = 8'h01;
    step();
    rst = 1'b0; start = 1'b0;
    #1 check_idle("rst_prio");

    // Randomised launches.
    for (int t = 0; t < 40; t++) begin
      run("rand", 1'($urandom), 16'($urandom), 8'($urandom), 0, 1'b1, 1'b0, 16'h0);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/lm_sm_seq.md
LM_SM_SEQ -- requirements
Module: lm_sm_seq

Interface
REQ-001 SHALL have parameter: W, 16, data and address width.
REQ-002 SHALL have port: clk  in  1  rising-edge clock, sole clock domain.
REQ-003 SHALL have port: rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  in  1  launch request; sampled only in IDLE.
REQ-005 SHALL have port: is_lm  in  1  1 = LM (memory to regs), 0 = SM (regs to memory); sampled with start.
REQ-006 SHALL have port: base_addr  in  W  first memory address; sampled with start.
REQ-007 SHALL have port: reg_mask  in  8  bit i selects Ri; sampled with start.
REQ-008 SHALL have ports: mem_req out 1, mem_we out 1, mem_addr out W, mem_wdata out W, mem_rdy in 1, mem_rdata in W; these form the memory handshake.
REQ-009 SHALL have ports: rf_rd_addr out 3 and rf_rd_data in W; the register-file read port is combinational.
REQ-010 SHALL have ports: rf_wr_en out 1, rf_wr_addr out 3, rf_wr_data out W; these form the register-file write port.
REQ-011 SHALL have ports: busy out 1 (not IDLE), done out 1 (one-cycle completion pulse).

Function
REQ-012 SHALL implement the FSM states IDLE, XFER and DONE.
REQ-013 SHALL, in IDLE with start=1, latch is_lm, base_addr and the effective mask, then go to XFER if the mask is nonzero, else to DONE.
REQ-014 SHALL define the current register idx as the lowest set bit of the latched mask, so registers transfer in ascending order.
REQ-015 SHALL, in XFER, drive mem_req=1, mem_addr=cur_addr, mem_we=~is_lm, rf_rd_addr=idx and mem_wdata=rf_rd_data, holding all of these stable until mem_rdy=1.
REQ-016 SHALL treat a cycle with mem_req&mem_rdy as a beat: clear mask bit idx, set cur_addr<=cur_addr+1 (0xFFFF wraps to 0x0000), and go to DONE if the remaining mask is zero.
REQ-017 SHALL, for LM on a beat cycle, drive rf_wr_en=1, rf_wr_addr=idx and rf_wr_data=mem_rdata in that same cycle; rf_wr_en SHALL be 0 in every other cycle and always 0 for SM.
REQ-018 SHALL, in DONE, assert done=1 for exactly one cycle and then return to IDLE; busy SHALL be 0 in IDLE only.
REQ-019 SHALL ignore start while busy=1; start asserted in the DONE cycle is also ignored.
REQ-020 SHALL, with mem_rdy held at 1 and n selected registers, complete n beats in cycles 1..n after start and pulse done in cycle n+1; with n=0, done SHALL pulse in cycle 1.
REQ-021 SHALL drive mem_req, mem_we and rf_wr_en to 0 outside XFER, and drive rf_rd_addr, rf_wr_addr, mem_addr and mem_wdata to 0 in IDLE.

Reset
REQ-022 SHALL, on rst=1 at a clk edge, go to IDLE and clear the latched mask, cur_addr and latched is_lm; in the following cycle busy, done, mem_req, mem_we and rf_wr_en SHALL be 0.
REQ-023 SHALL abort any sequence mid-operation on reset with no further beats, no done pulse, and no completion of registers already written.
REQ-024 SHALL give rst priority over start in the same cycle.

Configuration
REQ-025 SHALL, when the macro LMSM_PC_GUARD_EN is defined, clear reg_mask bit 7 at latch so R7 (PC) is never read or written; a mask of 0x80 then behaves as an empty mask.
REQ-026 SHALL, when LMSM_PC_GUARD_EN is undefined, treat bit 7 like any other bit, with R7 transferred last.

Verification
REQ-027 SHALL cover: SM, mask=0x05, base=0x0100, mem_rdy=1 -> beats (R0,0x0100) then (R2,0x0101), with mem_wdata equal to the rf data; done at cycle 3.
REQ-028 SHALL cover: LM, mask=0x0A, base=0x0200, mem_rdata=0xBEEF -> rf_wr_en pulses to R1 then R3 with data 0xBEEF; done at cycle 3.
REQ-029 SHALL cover: mask=0x00 -> no mem_req ever, done at cycle 1, busy high for exactly 1 cycle.
REQ-030 SHALL cover: LM, mask=0x01, mem_rdy low for 3 cycles -> mem_req/addr held stable for 4 cycles, a single rf write, done at cycle 5.
REQ-031 SHALL cover: SM, base=0xFFFF, mask=0x03 -> addresses 0xFFFF then 0x0000.
REQ-032 SHALL cover: rst asserted after first beat of mask=0xFF -> outputs idle next cycle, no done; with guard on, mask=0x80 -> done at cycle 1, no mem_req.
